// File: rtl/fifo_read_packer_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_read_packer_pkg
// Brief    : Shared constants, FSM encoding and width helper for the read-side
//            FIFO packer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_read_packer_pkg;

  // Default width of one FIFO entry (one output lane).
  localparam int C_DATAD_DEFAULT = 8;

  // FSM encoding.
  localparam logic [0:0] C_ST_FILL = 1'b0;
  localparam logic [0:0] C_ST_HOLD = 1'b1;

  typedef enum logic [0:0] {
    ST_FILL = C_ST_FILL,
    ST_HOLD = C_ST_HOLD
  } state_t;

  // Bits needed to represent values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_read_packer_out_reg.sv
//------------------------------------------------------------------------------
// Module   : packer_out_reg
// Brief    : One-entry valid/ready holding register. Accepts a new word whenever
//            it is empty or its current word is being taken downstream, so a
//            steady stream passes without bubbles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module packer_out_reg #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Load on an accepted input; otherwise drop valid once the word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_read_packer.sv
//------------------------------------------------------------------------------
// Module   : fifo_read_packer
// Brief    : Read-domain consumer of the dual-clock FIFO. Pops entries, packs
//            LANES of them into one wide word and offers it on a valid/ready
//            port; idle timeout or flush emits a partial word with keep mask.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_read_packer
  import fifo_read_packer_pkg::*;
#(
  parameter int DATAD   = C_DATAD_DEFAULT,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_r,
  input  logic                   rst,
  input  logic [DATAD-1:0]       fifo_out,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic [DATAD*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int CNT_W  = clog2_min1(LANES + 1);
  localparam int IDLE_W = clog2_min1(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(LANES - 1);
  localparam logic [IDLE_W-1:0] C_IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]    C_LANES_W  = (CNT_W + 1)'(LANES);

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pend;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_flush_lat;
  logic [LANES-1:0]   r_keep_hold;
  logic [DATAD-1:0]   r_lanes     [LANES];
  logic [DATAD-1:0]   w_cap_lanes [LANES];

  logic                     w_out_free;
  logic                     w_full_done;
  logic                     w_part_done;
  logic                     w_flush_eff;
  logic                     w_move_direct;
  logic                     w_move;
  logic [CNT_W-1:0]         w_cnt_nx;
  logic [CNT_W:0]           w_occupied;
  logic                     w_room;
  logic [LANES-1:0]         w_part_keep;
  logic [LANES-1:0]         w_move_keep;
  logic [DATAD*LANES-1:0]   w_word;

  // A full word completes in the cycle its last entry is being captured.
  assign w_full_done = (r_state == ST_FILL) && r_pend && (r_cnt == C_CNT_LAST);

  // A flush only matters when something is assembled or on its way.
  assign w_flush_eff = (flush && ((r_cnt != '0) || r_pend)) || r_flush_lat;

  // Partial words wait until the in-flight entry has landed.
  assign w_part_done = (r_state == ST_FILL) && !r_pend && (r_cnt != '0) &&
                       (w_flush_eff || (r_idle == C_IDLE_MAX));

  // A completed full word bypasses HOLD when the output register is free,
  // which keeps the pop stream continuous.
  assign w_move_direct = w_full_done && w_out_free;
  assign w_move        = w_move_direct || ((r_state == ST_HOLD) && w_out_free);
  assign w_move_keep   = w_move_direct ? {LANES{1'b1}} : r_keep_hold;

  // Reserve a lane for every entry already popped before popping another.
  assign w_cnt_nx   = w_move ? '0 : r_cnt;
  assign w_occupied = {1'b0, w_cnt_nx} + {{CNT_W{1'b0}}, r_pend};
  assign w_room     = (w_occupied < C_LANES_W);

  assign fifo_rd = !rst && !fifo_empty && (r_state == ST_FILL) &&
                   !w_flush_eff && !w_part_done && w_room;

  // Lane array as it will look after this cycle's capture.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_cap_lanes[i] = r_lanes[i];
      if (r_pend && (r_cnt == CNT_W'(i))) w_cap_lanes[i] = fifo_out;
    end
  end

  // Contiguous keep mask covering the lanes filled so far.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_part_keep[i] = (CNT_W'(i) < r_cnt);
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_flat
      assign w_word[g*DATAD +: DATAD] = w_cap_lanes[g];
    end
  endgenerate

  // Next-state logic: leave FILL when a word is ready but cannot move yet.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_FILL: if ((w_full_done && !w_out_free) || w_part_done) w_state_nx = ST_HOLD;
      ST_HOLD: if (w_out_free) w_state_nx = ST_FILL;
      default: w_state_nx = ST_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk_r) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nx;
  end

  // Lane array, fill count, in-flight flag, idle timer and flush latch.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_idle      <= '0;
      r_flush_lat <= 1'b0;
      r_keep_hold <= '0;
      for (int i = 0; i < LANES; i++) r_lanes[i] <= '0;
    end else begin
      r_pend <= fifo_rd;

      if (w_move) begin
        // Cleared lanes guarantee unused lanes of a later partial word are 0.
        for (int i = 0; i < LANES; i++) r_lanes[i] <= '0;
        r_cnt  <= '0;
        r_idle <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) r_lanes[i] <= w_cap_lanes[i];
        if (r_pend) r_cnt <= r_cnt + 1'b1;
        if (r_state == ST_FILL) begin
          if (r_pend)
            r_idle <= '0;
          else if ((r_cnt != '0) && (r_idle != C_IDLE_MAX))
            r_idle <= r_idle + 1'b1;
        end
      end

      if (w_part_done || w_move || (r_state == ST_HOLD))
        r_flush_lat <= 1'b0;
      else if (flush && r_pend && !w_full_done)
        r_flush_lat <= 1'b1;

      if (w_part_done)
        r_keep_hold <= w_part_keep;
      else if (w_full_done && !w_out_free)
        r_keep_hold <= {LANES{1'b1}};
    end
  end

  packer_out_reg #(
    .WIDTH (LANES + DATAD*LANES)
  ) u_out_reg (
    .clk       (clk_r),
    .rst       (rst),
    .in_valid  (w_move),
    .in_data   ({w_move_keep, w_word}),
    .in_ready  (w_out_free),
    .out_valid (m_valid),
    .out_data  ({m_keep, m_data}),
    .out_ready (m_ready)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_read_packer
// Brief    : Directed and randomised self-checking bench for fifo_read_packer
//            with a behavioural FIFO model on the read interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_read_packer;

  logic        clk_r;
  logic        rst;
  logic [7:0]  fifo_out;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  fifo_read_packer #(.DATAD(8), .LANES(4), .TIMEOUT(16)) dut (
    .clk_r      (clk_r),
    .rst        (rst),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  initial begin
    clk_r = 1'b0;
    forever #5 clk_r = ~clk_r;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  fq[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_keep[$];
  int          obs_cyc[$];
  int          pop_cyc[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  int          cyc = 0;
  int          pops = 0;
  int          run_len = 0;
  int          max_run = 0;
  int          rd_viol = 0;
  int          stab_viol = 0;
  logic        empty_force = 1'b0;
  logic        s_rd, s_mv;
  logic [31:0] s_md;
  logic [3:0]  s_mk;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_md = '0;
  logic [3:0]  prev_mk = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read-clock cycle: sample before the rising edge, model the FIFO pop after it.
  task automatic tick();
    fifo_empty = (fq.size() == 0) || empty_force;
    #4;
    s_rd = fifo_rd;
    s_mv = m_valid;
    s_md = m_data;
    s_mk = m_keep;
    if (s_rd && fifo_empty) rd_viol++;
    if (prev_hold && (!s_mv || s_md != prev_md || s_mk != prev_mk)) stab_viol++;
    prev_hold = s_mv && !m_ready;
    prev_md   = s_md;
    prev_mk   = s_mk;
    if (s_rd) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (s_mv && m_ready) begin
      obs_data.push_back(s_md);
      obs_keep.push_back(s_mk);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk_r);
    #1;
    if (s_rd && !fifo_empty) begin
      fifo_out = fq.pop_front();
      pops++;
      pop_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk_r);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_keep.delete();
    obs_cyc.delete();
    pop_cyc.delete();
    pops    = 0;
    max_run = 0;
    run_len = 0;
  endtask

  initial begin
    rst        = 1'b1;
    fifo_out   = '0;
    fifo_empty = 1'b1;
    flush      = 1'b0;
    m_ready    = 1'b1;

    // Reset with data waiting: no pops, cleared output port.
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    tick();
    tick();
    check("reset_fifo_rd", s_rd, 0);
    check("reset_m_valid", s_mv, 0);
    check("reset_m_data", s_md, 0);
    check("reset_m_keep", s_mk, 0);
    rst = 1'b0;

    // Back-to-back full words.
    clear_obs();
    repeat (16) tick();
    check("full_words", obs_data.size(), 2);
    check("full_pops", pops, 8);
    check("full_rd_run", max_run, 8);
    if (obs_data.size() >= 2 && pop_cyc.size() >= 4) begin
      check("full_w0_data", obs_data[0], 32'h04030201);
      check("full_w0_keep", obs_keep[0], 4'hF);
      check("full_w1_data", obs_data[1], 32'h08070605);
      check("full_w1_keep", obs_keep[1], 4'hF);
      check("full_latency", obs_cyc[0] - pop_cyc[3], 2);
    end

    // Idle timeout emits a 3-lane partial word, then nothing more.
    clear_obs();
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    fq.push_back(8'hCC);
    repeat (45) tick();
    check("tmo_words", obs_data.size(), 1);
    if (obs_data.size() >= 1 && pop_cyc.size() >= 3) begin
      check("tmo_data", obs_data[0], 32'h00CCBBAA);
      check("tmo_keep", obs_keep[0], 4'h7);
      check("tmo_latency", obs_cyc[0] - pop_cyc[2], 19);
    end

    // Flush while the second entry is in flight; third entry stays in the FIFO.
    clear_obs();
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    for (int i = 0; i < 10 && pops < 2; i++) tick();
    check("flush_setup_pops", pops, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_no_pop", s_rd, 0);
    repeat (40) tick();
    check("flush_words", obs_data.size(), 2);
    if (obs_data.size() >= 2) begin
      check("flush_w0_data", obs_data[0], 32'h00002211);
      check("flush_w0_keep", obs_keep[0], 4'h3);
      check("flush_w1_data", obs_data[1], 32'h00000033);
      check("flush_w1_keep", obs_keep[1], 4'h1);
    end

    // Backpressure: one word held at the output, one in HOLD, pops stop.
    clear_obs();
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
    repeat (20) tick();
    check("bp_pops", pops, 8);
    check("bp_m_valid", s_mv, 1);
    check("bp_m_data", s_md, 32'h04030201);
    check("bp_m_keep", s_mk, 4'hF);
    m_ready = 1'b1;
    repeat (20) tick();
    check("bp_words", obs_data.size(), 3);
    if (obs_data.size() >= 3) begin
      check("bp_w0", obs_data[0], 32'h04030201);
      check("bp_w1", obs_data[1], 32'h08070605);
      check("bp_w2", obs_data[2], 32'h0C0B0A09);
    end

    // Reset with two lanes assembled and one entry in flight.
    clear_obs();
    for (int i = 1; i <= 8; i++) fq.push_back(8'hA0 + 8'(i));
    repeat (3) tick();
    check("rst_mid_pops", pops, 3);
    rst = 1'b1;
    tick();
    check("rst_mid_fifo_rd", s_rd, 0);
    rst = 1'b0;
    tick();
    check("rst_mid_m_valid", s_mv, 0);
    check("rst_mid_m_data", s_md, 0);
    check("rst_mid_m_keep", s_mk, 0);
    repeat (40) tick();
    check("rst_mid_words", obs_data.size(), 2);
    if (obs_data.size() >= 2) begin
      check("rst_mid_w0", obs_data[0], 32'hA7A6A5A4);
      check("rst_mid_w0_keep", obs_keep[0], 4'hF);
      check("rst_mid_w1", obs_data[1], 32'h000000A8);
      check("rst_mid_w1_keep", obs_keep[1], 4'h1);
    end

    // Random FIFO availability and downstream backpressure.
    clear_obs();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      fq.push_back(b);
      exp_q.push_back(b);
    end
    for (int i = 0; i < 1000; i++) begin
      empty_force = ($urandom_range(0, 3) == 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    empty_force = 1'b0;
    m_ready     = 1'b1;
    for (int i = 0; i < 600 && fq.size() != 0; i++) tick();
    repeat (40) tick();
    begin
      int lane_viol;
      int keep_viol;
      int n;
      lane_viol = 0;
      keep_viol = 0;
      for (int w = 0; w < obs_data.size(); w++) begin
        logic [31:0] d;
        logic [3:0]  k;
        d = obs_data[w];
        k = obs_keep[w];
        if (k == 4'h0 || ((k & (k + 4'h1)) != 4'h0)) keep_viol++;
        for (int l = 0; l < 4; l++) begin
          if (k[l]) got_q.push_back(d[l*8 +: 8]);
          else if (d[l*8 +: 8] != 8'h00) lane_viol++;
        end
      end
      check("rand_stream_len", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("rand_byte", got_q[i], exp_q[i]);
      check("rand_keep_contig", keep_viol, 0);
      check("rand_unused_lanes", lane_viol, 0);
    end

    check("rd_while_empty", rd_viol, 0);
    check("out_stable_stall", stab_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
